// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arb
//  Purpose  : Two-requester round-robin arbiter in front of the single-port,
//             synchronous-read data memory. Requester 0 is the core load/store
//             port, requester 1 the host loader/debug port. At most one access
//             is issued every two cycles; a requester may lock ownership
//             across consecutive accesses for atomic read-modify-write.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  // DEPTH only documents the memory size; flag an inconsistent setting early.
  generate
    if (DEPTH != (1 << ADDR_W)) begin : g_depth_mismatch
      $error("dmem_arb: DEPTH must equal 2**ADDR_W");
    end
  endgenerate

  logic [0:0] state;
  logic [0:0] state_next;
  logic       sel;        // requester being served in ISSUE
  logic       last;       // requester served most recently
  logic       owner_vld;  // a lock is held
  logic       owner_id;   // which requester holds the lock
  logic       pick_vld;
  logic       pick;
  logic       owner_req;
  logic       we_sel;
  logic       lock_sel;

  assign owner_req = owner_id ? req1 : req0;
  assign we_sel    = sel ? we1   : we0;
  assign lock_sel  = sel ? lock1 : lock0;

  // Read data is broadcast; rvalid tells each requester when it is theirs.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

  // Arbitration: locked owner first, then a lone requester, then round-robin.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 1'b0;
    if (owner_vld && owner_req) begin
      pick_vld = 1'b1;
      pick     = owner_id;
    end else if (req0 ^ req1) begin
      pick_vld = 1'b1;
      pick     = req1;
    end else if (req0 && req1) begin
      pick_vld = 1'b1;
      pick     = ~last;
    end
  end

  // Next state: IDLE waits for a winner, ISSUE always lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_vld) state_next = ISSUE;
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus winner, round-robin history, lock owner and rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      owner_vld <= 1'b0;
      owner_id  <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      state   <= state_next;
      rvalid0 <= (state == ISSUE) && !sel && !we_sel;
      rvalid1 <= (state == ISSUE) &&  sel && !we_sel;
      if (state == IDLE) begin
        if (pick_vld) sel <= pick;
        // An owner that stops requesting gives up its lock.
        if (owner_vld && !owner_req) owner_vld <= 1'b0;
      end else begin
        last      <= sel;
        owner_vld <= lock_sel;
        owner_id  <= sel;
      end
    end
  end

  // Memory strobes and grants are driven only during ISSUE, from sel's inputs.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (state == ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = we_sel;
      mem_addr  = sel ? addr1  : addr0;
      mem_wdata = sel ? wdata1 : wdata0;
      gnt0      = ~sel;
      gnt1      = sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arb
//  Purpose  : Self-checking bench for dmem_arb with a behavioural dmem.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arb;

  logic       clk;
  logic       rst;
  logic       req0, we0, lock0, req1, we1, lock1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [16];
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;

  int checks;
  int failures;

  typedef struct packed {
    logic       r;
    logic       w;
    logic       l;
    logic [3:0] a;
    logic [7:0] d;
  } port_t;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       en;
    logic       we;
    logic [3:0] ma;
    logic [7:0] md;
    logic       v0;
    logic       v1;
  } exp_t;

  typedef struct {
    logic       rst;
    port_t      p0;
    port_t      p1;
    exp_t       e;
    logic [1:0] push;   // 0 none, 1 read return on port 0, 2 on port 1
    logic [7:0] pdata;
  } vec_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[$];

  dmem_arb #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous-read memory with a bench preload port.
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  localparam port_t NOP  = '0;
  localparam exp_t  NONE = '0;

  function automatic port_t rd(input logic [3:0] a);
    port_t p = '0;
    p.r = 1'b1; p.a = a;
    return p;
  endfunction

  function automatic port_t rdl(input logic [3:0] a);
    port_t p = rd(a);
    p.l = 1'b1;
    return p;
  endfunction

  function automatic port_t wr(input logic [3:0] a, input logic [7:0] d);
    port_t p = '0;
    p.r = 1'b1; p.w = 1'b1; p.a = a; p.d = d;
    return p;
  endfunction

  // Idle-looking port: no request but busy address/data/lock lines.
  function automatic port_t junk(input logic [3:0] a, input logic [7:0] d);
    port_t p = '0;
    p.w = 1'b1; p.l = 1'b1; p.a = a; p.d = d;
    return p;
  endfunction

  function automatic exp_t gnt(input logic p, input logic we,
                               input logic [3:0] a, input logic [7:0] d);
    exp_t e = '0;
    e.g0 = ~p; e.g1 = p; e.en = 1'b1; e.we = we; e.ma = a; e.md = d;
    return e;
  endfunction

  function automatic exp_t rv(input logic p);
    exp_t e = '0;
    e.v0 = ~p; e.v1 = p;
    return e;
  endfunction

  function automatic vec_t row(input port_t p0, input port_t p1, input exp_t e,
                               input logic [1:0] push = 2'd0,
                               input logic [7:0] pd = 8'h00);
    vec_t v;
    v.rst = 1'b0; v.p0 = p0; v.p1 = p1; v.e = e; v.push = push; v.pdata = pd;
    return v;
  endfunction

  // Drive one cycle of stimulus, compare at the falling edge, then pop any
  // read return against the scoreboard.
  task automatic run(input vec_t v, input string tag, input int idx);
    exp_t got;
    sb_t  s;
    sb_t  act;
    rst    = v.rst;
    req0   = v.p0.r; we0 = v.p0.w; lock0 = v.p0.l; addr0 = v.p0.a; wdata0 = v.p0.d;
    req1   = v.p1.r; we1 = v.p1.w; lock1 = v.p1.l; addr1 = v.p1.a; wdata1 = v.p1.d;
    if (v.push == 2'd1) sb_q.push_back({1'b0, v.pdata});
    if (v.push == 2'd2) sb_q.push_back({1'b1, v.pdata});
    @(negedge clk);
    got = {gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata, rvalid0, rvalid1};
    checks++;
    if (got !== v.e) begin
      failures++;
      $display("FAIL %s[%0d] outputs {g0,g1,en,we,addr,wdata,v0,v1} got=%h exp=%h",
               tag, idx, got, v.e);
    end
    if (rvalid0 || rvalid1) begin
      checks++;
      act = {rvalid1, rvalid1 ? rdata1 : rdata0};
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL %s[%0d] rdata unexpected rvalid port=%0d data=%h exp=none",
                 tag, idx, act.port, act.data);
      end else begin
        s = sb_q.pop_front();
        if (act !== s) begin
          failures++;
          $display("FAIL %s[%0d] rdata port/data got=%0d/%h exp=%0d/%h",
                   tag, idx, act.port, act.data, s.port, s.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n_a;
    vec_t v;
    checks = 0; failures = 0;
    rst = 1'b1;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    load_en = 1'b1; load_addr = 0; load_data = 0;

    // Preload: word i = {i,i}, with a few distinctive values.
    for (int i = 0; i < 16; i++) begin
      load_addr = 4'(i);
      case (i)
        0:       load_data = 8'hA0;
        1:       load_data = 8'hB1;
        3:       load_data = 8'h5A;
        5:       load_data = 8'h77;
        default: load_data = {4'(i), 4'(i)};
      endcase
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;

    // Reset state.
    v = row(junk(4'h7, 8'hFF), junk(4'h9, 8'h5C), NONE);
    v.rst = 1'b1;
    run(v, "reset", 0);
    run(v, "reset", 1);

    // Part A: tie after reset with round-robin, single read, single write.
    tbl.push_back(row(rd(0), rd(1), NONE));
    tbl.push_back(row(rd(0), rd(1), gnt(0, 0, 4'd0, 8'h00), 2'd1, 8'hA0));
    tbl.push_back(row(rd(0), rd(1), rv(0)));
    tbl.push_back(row(rd(0), rd(1), gnt(1, 0, 4'd1, 8'h00), 2'd2, 8'hB1));
    tbl.push_back(row(rd(0), rd(1), rv(1)));
    tbl.push_back(row(rd(0), rd(1), gnt(0, 0, 4'd0, 8'h00), 2'd1, 8'hA0));
    tbl.push_back(row(rd(0), rd(1), rv(0)));
    tbl.push_back(row(rd(0), rd(1), gnt(1, 0, 4'd1, 8'h00), 2'd2, 8'hB1));
    tbl.push_back(row(NOP,   NOP,   rv(1)));
    tbl.push_back(row(rd(3), NOP,   NONE));
    tbl.push_back(row(rd(3), NOP,   gnt(0, 0, 4'd3, 8'h00), 2'd1, 8'h5A));
    tbl.push_back(row(NOP,   NOP,   rv(0)));
    tbl.push_back(row(NOP,   wr(2, 8'hC3), NONE));
    tbl.push_back(row(NOP,   wr(2, 8'hC3), gnt(1, 1, 4'd2, 8'hC3)));
    tbl.push_back(row(NOP,   NOP,   NONE));
    n_a = tbl.size();
    // Part B: read back the written word, then a quiet stretch.
    tbl.push_back(row(rd(2), NOP,   NONE));
    tbl.push_back(row(rd(2), NOP,   gnt(0, 0, 4'd2, 8'h00), 2'd1, 8'hC3));
    tbl.push_back(row(NOP,   NOP,   rv(0)));
    for (int i = 0; i < 10; i++)
      tbl.push_back(row(junk(4'h7, 8'hFF), junk(4'h9, 8'h5C), NONE));

    for (int i = 0; i < n_a; i++) run(tbl[i], "tbl", i);

    // Locked read-modify-write by port 0 while port 1 keeps requesting.
    run(row(rdl(5), rd(4), NONE), "lock", 0);
    run(row(rdl(5), rd(4), gnt(0, 0, 4'd5, 8'h00), 2'd1, 8'h77), "lock", 1);
    run(row(wr(5, 8'h11), rd(4), rv(0)), "lock", 2);
    run(row(wr(5, 8'h11), rd(4), gnt(0, 1, 4'd5, 8'h11)), "lock", 3);
    run(row(NOP, rd(4), NONE), "lock", 4);
    run(row(NOP, rd(4), gnt(1, 0, 4'd4, 8'h00), 2'd2, 8'h44), "lock", 5);
    run(row(NOP, NOP, rv(1)), "lock", 6);
    run(row(rd(5), NOP, NONE), "lock", 7);
    run(row(rd(5), NOP, gnt(0, 0, 4'd5, 8'h00), 2'd1, 8'h11), "lock", 8);
    run(row(NOP, NOP, rv(0)), "lock", 9);

    for (int i = n_a; i < tbl.size(); i++) run(tbl[i], "tbl", i);

    // Reset during the grant cycle of a read: no rvalid, tie goes to port 0.
    run(row(rd(3), NOP, NONE), "rstiss", 0);
    v = row(rd(3), NOP, gnt(0, 0, 4'd3, 8'h00));
    v.rst = 1'b1;
    run(v, "rstiss", 1);
    run(row(rd(0), rd(1), NONE), "rstiss", 2);
    run(row(rd(0), rd(1), gnt(0, 0, 4'd0, 8'h00), 2'd1, 8'hA0), "rstiss", 3);
    run(row(NOP, NOP, rv(0)), "rstiss", 4);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain outstanding reads got=%0d exp=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
